// File: rtl/ex_mem_dmem_stage.sv
// EX/MEM register + data-memory req/ready controller; captures in 1 cycle, loads/stores add >=1 stall cycle.
// Backpressure: holds while Stall (= Stall_ext | access outstanding); memory latency is absorbed by mem_ready.
module ex_mem_dmem_stage #(
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              Stall_ext,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              MemToReg_EX,
    input  logic              RegWrite_EX,
    input  logic [31:0]       ALU_result_EX,
    input  logic [31:0]       WriteData_EX,
    input  logic [4:0]        WriteReg_Addr_EX,
    output logic              Stall,
    output logic              MemToReg_MEM,
    output logic              RegWrite_MEM,
    output logic [31:0]       ALU_result_MEM,
    output logic [4:0]        WriteReg_Addr_MEM,
    output logic [31:0]       Mem_Data_MEM,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [29:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              Misalign,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] wdata_q;
    logic        misalign_q;
    logic        busy;
    logic        capture;
    logic        mem_acc;
    logic        misaligned;

    assign busy       = (state == WAIT);
    assign Stall      = Stall_ext | busy;
    assign capture    = ~Stall;
    assign mem_acc    = MemRead_EX | MemWrite_EX;
    assign misaligned = mem_acc & (|ALU_result_EX[1:0]);

    assign mem_req   = busy;
    assign mem_wen   = busy & mem_write_q;
    assign mem_addr  = ALU_result_MEM[31:2];
    assign mem_wdata = wdata_q;
    assign Misalign  = misalign_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture && mem_acc && !misaligned) state_nxt = WAIT;
            WAIT: if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state             <= IDLE;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            wdata_q           <= '0;
            misalign_q        <= 1'b0;
            MemToReg_MEM      <= 1'b0;
            RegWrite_MEM      <= 1'b0;
            ALU_result_MEM    <= '0;
            WriteReg_Addr_MEM <= '0;
            Mem_Data_MEM      <= '0;
            stall_cnt         <= '0;
        end else begin
            state      <= state_nxt;
            misalign_q <= capture & misaligned;

            if (busy && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;

            // A misaligned access is turned into a bubble: no writeback, no memory request.
            if (capture) begin
                mem_read_q        <= MemRead_EX & ~misaligned;
                mem_write_q       <= MemWrite_EX & ~misaligned;
                wdata_q           <= WriteData_EX;
                MemToReg_MEM      <= MemToReg_EX;
                RegWrite_MEM      <= RegWrite_EX & ~misaligned;
                ALU_result_MEM    <= ALU_result_EX;
                WriteReg_Addr_MEM <= WriteReg_Addr_EX;
            end

            if (busy && mem_ready && mem_read_q)
                Mem_Data_MEM <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ex_mem_dmem_stage.sv
// Directed bench for ex_mem_dmem_stage: vector table for single-cycle captures plus hand sequences for memory accesses.
module tb_ex_mem_dmem_stage;

    logic        Clk = 1'b0;
    logic        rst;
    logic        Stall_ext;
    logic        MemRead_EX, MemWrite_EX, MemToReg_EX, RegWrite_EX;
    logic [31:0] ALU_result_EX, WriteData_EX;
    logic [4:0]  WriteReg_Addr_EX;
    logic        Stall, MemToReg_MEM, RegWrite_MEM;
    logic [31:0] ALU_result_MEM, Mem_Data_MEM;
    logic [4:0]  WriteReg_Addr_MEM;
    logic        mem_req, mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        Misalign;
    logic [1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    // Narrow counter so saturation is reachable in a few cycles.
    ex_mem_dmem_stage #(.CNT_W(2)) dut (
        .Clk(Clk), .rst(rst), .Stall_ext(Stall_ext),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemToReg_EX(MemToReg_EX), .RegWrite_EX(RegWrite_EX),
        .ALU_result_EX(ALU_result_EX), .WriteData_EX(WriteData_EX),
        .WriteReg_Addr_EX(WriteReg_Addr_EX),
        .Stall(Stall), .MemToReg_MEM(MemToReg_MEM), .RegWrite_MEM(RegWrite_MEM),
        .ALU_result_MEM(ALU_result_MEM), .WriteReg_Addr_MEM(WriteReg_Addr_MEM),
        .Mem_Data_MEM(Mem_Data_MEM),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .Misalign(Misalign), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        ext, mr, mw, m2r, rw;
        logic [31:0] alu, wd;
        logic [4:0]  wa;
        logic        e_stall, e_m2r, e_rw;
        logic [31:0] e_alu;
        logic [4:0]  e_wa;
        logic        e_mis;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_ex(input logic mr, input logic mw, input logic m2r, input logic rw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wa);
        MemRead_EX       = mr;
        MemWrite_EX      = mw;
        MemToReg_EX      = m2r;
        RegWrite_EX      = rw;
        ALU_result_EX    = alu;
        WriteData_EX     = wd;
        WriteReg_Addr_EX = wa;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55,        32'h0,    5'd7,
                    1'b0, 1'b0, 1'b1, 32'h55,        5'd7,  1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h99,        32'h0,    5'd3,
                    1'b1, 1'b0, 1'b1, 32'h55,        5'd7,  1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h13,        32'h0,    5'd9,
                    1'b0, 1'b1, 1'b0, 32'h13,        5'd9,  1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0,    5'd31,
                    1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 5'd31, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22,        32'h1111, 5'd0,
                    1'b0, 1'b0, 1'b0, 32'h22,        5'd0,  1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h26,        32'h1111, 5'd2,
                    1'b1, 1'b0, 1'b0, 32'h22,        5'd0,  1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,       32'h0,    5'd1,
                    1'b0, 1'b0, 1'b1, 32'h100,       5'd1,  1'b0};

        Stall_ext = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        drive_ex(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        reset_dut();

        // Reset state
        chk("rst_stall", Stall, 0);
        chk("rst_m2r", MemToReg_MEM, 0);
        chk("rst_rw", RegWrite_MEM, 0);
        chk("rst_alu", ALU_result_MEM, 0);
        chk("rst_wa", WriteReg_Addr_MEM, 0);
        chk("rst_mdata", Mem_Data_MEM, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_mis", Misalign, 0);
        chk("rst_cnt", stall_cnt, 0);

        // Single-cycle captures, holds and misaligned bubbles
        for (int i = 0; i < 7; i++) begin
            Stall_ext = vecs[i].ext;
            drive_ex(vecs[i].mr, vecs[i].mw, vecs[i].m2r, vecs[i].rw, vecs[i].alu, vecs[i].wd, vecs[i].wa);
            tick();
            chk($sformatf("v%0d_stall", i), Stall, vecs[i].e_stall);
            chk($sformatf("v%0d_m2r", i), MemToReg_MEM, vecs[i].e_m2r);
            chk($sformatf("v%0d_rw", i), RegWrite_MEM, vecs[i].e_rw);
            chk($sformatf("v%0d_alu", i), ALU_result_MEM, vecs[i].e_alu);
            chk($sformatf("v%0d_wa", i), WriteReg_Addr_MEM, vecs[i].e_wa);
            chk($sformatf("v%0d_mis", i), Misalign, vecs[i].e_mis);
            chk($sformatf("v%0d_req", i), mem_req, 0);
        end
        Stall_ext = 1'b0;

        // Load at 0x10, ready in the 3rd WAIT cycle; EX inputs change meanwhile
        drive_ex(1, 0, 1, 1, 32'h10, 32'h0, 5'd4);
        tick();
        drive_ex(0, 0, 0, 1, 32'hFFF0, 32'h0, 5'd2);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            #1;
            chk($sformatf("ld_req_c%0d", c), mem_req, 1);
            chk($sformatf("ld_addr_c%0d", c), mem_addr, 30'h4);
            chk($sformatf("ld_wen_c%0d", c), mem_wen, 0);
            chk($sformatf("ld_stall_c%0d", c), Stall, 1);
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("ld_done_stall", Stall, 0);
        chk("ld_done_req", mem_req, 0);
        chk("ld_done_mdata", Mem_Data_MEM, 32'h1234_5678);
        chk("ld_done_cnt", stall_cnt, 3);
        chk("ld_done_alu", ALU_result_MEM, 32'h10);

        // Store at 0x20, ready in the first WAIT cycle; counter already saturated
        drive_ex(0, 1, 0, 0, 32'h20, 32'hCAFE_F00D, 5'd0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        drive_ex(0, 0, 0, 0, 32'h44, 32'h5555, 5'd0);
        #1;
        chk("st_req", mem_req, 1);
        chk("st_wen", mem_wen, 1);
        chk("st_addr", mem_addr, 30'h8);
        chk("st_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("st_stall", Stall, 1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("st_done_stall", Stall, 0);
        chk("st_done_req", mem_req, 0);
        chk("st_done_mdata", Mem_Data_MEM, 32'h1234_5678);
        chk("st_cnt_sat", stall_cnt, 3);

        // Load with Stall_ext raised for the whole access and beyond
        reset_dut();
        drive_ex(1, 0, 1, 1, 32'h40, 32'h0, 5'd5);
        tick();
        Stall_ext = 1'b1;
        #1;
        chk("ext_req1", mem_req, 1);
        chk("ext_stall1", Stall, 1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ext_req2", mem_req, 1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("ext_done_stall", Stall, 1);
        chk("ext_done_mdata", Mem_Data_MEM, 32'hDEAD_BEEF);
        chk("ext_done_cnt", stall_cnt, 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ext_noreq%0d", k), mem_req, 0);
            chk($sformatf("ext_hold_alu%0d", k), ALU_result_MEM, 32'h40);
            chk($sformatf("ext_cnt%0d", k), stall_cnt, 2);
        end
        drive_ex(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        Stall_ext = 1'b0;
        tick();
        chk("ext_rel_req", mem_req, 0);
        chk("ext_rel_stall", Stall, 0);

        // Reset during WAIT abandons the access
        drive_ex(1, 0, 1, 1, 32'h44, 32'h0, 5'd6);
        tick();
        drive_ex(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("rw_req_before", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rw_req", mem_req, 0);
        chk("rw_stall", Stall, 0);
        chk("rw_rw", RegWrite_MEM, 0);
        chk("rw_alu", ALU_result_MEM, 0);
        chk("rw_wa", WriteReg_Addr_MEM, 0);
        chk("rw_m2r", MemToReg_MEM, 0);
        chk("rw_cnt", stall_cnt, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("rw_late_mdata", Mem_Data_MEM, 0);
        chk("rw_late_req", mem_req, 0);
        chk("rw_late_stall", Stall, 0);
        tick();
        chk("rw_late_req2", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_dmem_stage.md
Name: ex_mem_dmem_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller for the pipelined MIPS core.
- Sits directly upstream of the MEM/WB writeback stage and drives its MemToReg_MEM, RegWrite_MEM, ALU_result_MEM, WriteReg_Addr_MEM and Mem_Data_MEM inputs.
- Runs a req/ready handshake with a variable-latency data memory and raises the global pipeline Stall while an access is outstanding.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Stall_ext  input  1  stall request from other pipeline sources (e.g. I-cache).
- MemRead_EX  input  1  EX instruction is a load.
- MemWrite_EX  input  1  EX instruction is a store.
- MemToReg_EX  input  1  writeback selects memory data.
- RegWrite_EX  input  1  instruction writes the register file.
- ALU_result_EX  input  32  ALU result / byte address.
- WriteData_EX  input  32  store data.
- WriteReg_Addr_EX  input  5  destination register.
- Stall  output  1  global pipeline stall = Stall_ext | busy.
- MemToReg_MEM, RegWrite_MEM  output  1 each  registered controls.
- ALU_result_MEM  output  32  registered ALU result.
- WriteReg_Addr_MEM  output  5  registered destination.
- Mem_Data_MEM  output  32  registered load data.
- mem_req  output  1  memory request.
- mem_wen  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  30  word address = ALU_result_MEM[31:2].
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data; valid when mem_ready.
- mem_ready  input  1  access complete.
- Misalign  output  1  one-cycle pulse on a misaligned load/store capture.
- stall_cnt  output  CNT_W  count of cycles in which busy = 1, saturating.

Behaviour:
- Reset (rst sampled high at an edge):
  - All outputs and registers go to 0; state goes to IDLE.
  - Applies mid-access: mem_req drops the next cycle and the pending access is abandoned.
- Capture: at an edge with Stall = 0, the EX/MEM register loads all *_EX fields, including internal MemRead/MemWrite and the store data. With Stall = 1 every register holds.
- Misaligned access:
  - Condition: a capture with (MemRead_EX | MemWrite_EX) and ALU_result_EX[1:0] != 0.
  - Captured as a bubble: RegWrite_MEM = 0, no request, state stays IDLE.
  - Misalign = 1 for exactly the cycle after that edge.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT: a capture of an aligned load/store.
  - WAIT -> IDLE: the edge where mem_ready = 1.
  - No other transitions (except reset).
- busy = (state == WAIT).
- While in WAIT:
  - mem_req = 1; mem_wen = stored MemWrite.
  - mem_addr and mem_wdata stay stable until mem_ready is sampled.
  - In IDLE, mem_req = 0 and mem_ready is ignored.
- Load completion: at the WAIT->IDLE edge, Mem_Data_MEM <= mem_rdata. Stores leave Mem_Data_MEM unchanged.
- Stall remains 1 through the cycle in which mem_ready is high. The following cycle Stall = Stall_ext, with Mem_Data_MEM already valid, so the downstream stage captures correct data.
- Minimum load/store penalty: 1 stall cycle (mem_ready high in the first WAIT cycle). Penalty = N stall cycles when ready arrives in WAIT cycle N.
- Stall_ext during WAIT: the access still completes and the state returns to IDLE. The register holds and no re-issue occurs until a new capture.
- Non-memory instructions never stall locally; Stall = Stall_ext.
- stall_cnt: increments by 1 each cycle busy = 1 and saturates at 2^CNT_W - 1. Stall_ext cycles are not counted.

Test Plan:
- Load lw addr 0x0000_0010, mem_ready high on 3rd WAIT cycle, mem_rdata = 0x1234_5678 -> mem_req high 3 cycles with mem_addr = 0x4 and mem_wen = 0; Stall high 3 cycles; next cycle Mem_Data_MEM = 0x1234_5678, Stall = 0; stall_cnt = 3.
- Store sw addr 0x20, data 0xCAFE_F00D, mem_ready in first WAIT cycle -> one request cycle with mem_wen = 1, mem_addr = 0x8, mem_wdata = 0xCAFE_F00D; Stall high exactly 1 cycle; Mem_Data_MEM unchanged.
- ALU instruction (RegWrite = 1, result 0x55, rd = 7) -> captured next edge; no mem_req, Stall = 0; ALU_result_MEM = 0x55, WriteReg_Addr_MEM = 7.
- Load with Stall_ext held high throughout, mem_ready after 2 cycles -> access completes, state IDLE; Stall stays high while Stall_ext is high; no second mem_req; stall_cnt = 2.
- Load at address 0x13 -> no mem_req; Misalign pulses 1 cycle; RegWrite_MEM = 0.
- rst asserted during WAIT before mem_ready -> next cycle mem_req = 0, Stall = 0, all outputs 0. A subsequent mem_ready pulse causes no state change.
